// File: rtl/interrupt_requester.sv
// Requester half of the int/ack interrupt handshake: latches source edges,
// picks the lowest-index unmasked pending source and holds it until ack.
module interrupt_requester #(
    parameter int          NSRC       = 4,
    parameter int          IDW        = 2,
    parameter logic [15:0] VEC_BASE   = 16'h0002,
    parameter int          GAP_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [NSRC-1:0] mask,
    input  logic            ack,
    output logic            int_req,
    output logic [IDW-1:0]  irq_id,
    output logic [15:0]     irq_vector,
    output logic [NSRC-1:0] pending,
    output logic [15:0]     serviced_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_ACKD = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]      state;
    logic [3:0]      gap_cnt;
    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] clr_bit;
    logic [NSRC-1:0] pending_n;
    logic [IDW-1:0]  win_id;
    logic            win_vld;
    logic            take_ack;

    assign rise     = src & ~src_q;
    assign cand     = pending & mask;
    assign win_vld  = |cand;
    assign take_ack = (state == S_REQ) && ack;

    // Scan from the top so the lowest index is the last one written.
    always_comb begin
        win_id = '0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (cand[k]) begin
                win_id = IDW'(k);
            end
        end
    end

    always_comb begin
        clr_bit = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (take_ack && (irq_id == IDW'(k))) begin
                clr_bit[k] = 1'b1;
            end
        end
    end

    // A fresh edge on the bit being serviced keeps it pending.
    assign pending_n = (pending & ~clr_bit) | rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q   <= '0;
            pending <= '0;
        end else begin
            src_q   <= src;
            pending <= pending_n;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            serviced_cnt <= '0;
        end else if (take_ack) begin
            serviced_cnt <= serviced_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            gap_cnt    <= '0;
            int_req    <= 1'b0;
            irq_id     <= '0;
            irq_vector <= VEC_BASE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        irq_id     <= win_id;
                        irq_vector <= VEC_BASE + 16'(win_id);
                        int_req    <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        int_req <= 1'b0;
                        state   <= S_ACKD;
                    end
                end
                S_ACKD: begin
                    if (!ack) begin
                        if (GAP_CYCLES == 0) begin
                            state <= S_IDLE;
                        end else begin
                            gap_cnt <= 4'(GAP_CYCLES);
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - 4'd1;
                    if (gap_cnt <= 4'd1) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_requester.sv
// Directed and randomized checks of interrupt_requester against a
// cycle-level handshake model.
module tb_interrupt_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src;
    logic [3:0]  mask;
    logic        ack;
    logic        int_req;
    logic [1:0]  irq_id;
    logic [15:0] irq_vector;
    logic [3:0]  pending;
    logic [15:0] serviced_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    interrupt_requester #(
        .NSRC(4), .IDW(2), .VEC_BASE(16'h0002), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .src(src), .mask(mask), .ack(ack),
        .int_req(int_req), .irq_id(irq_id), .irq_vector(irq_vector),
        .pending(pending), .serviced_cnt(serviced_cnt)
    );

    // Reference: a request is outstanding, then we wait for ack to drop,
    // then a hold-off of GAP cycles before a new request may be raised.
    bit [3:0]  m_sq;
    bit [3:0]  m_pend;
    bit        m_int;
    bit [1:0]  m_id;
    bit [15:0] m_cnt;
    bit        m_waitlow;
    int        m_hold;

    task automatic model_reset();
        m_sq = 0; m_pend = 0; m_int = 0; m_id = 0;
        m_cnt = 0; m_waitlow = 0; m_hold = 0;
    endtask

    task automatic model_clk();
        bit [3:0] r;
        bit [3:0] cnd;
        bit [3:0] np;
        r   = src & ~m_sq;
        cnd = m_pend & mask;
        np  = m_pend;
        if (m_int) begin
            if (ack) begin
                m_int = 0;
                np[m_id] = 1'b0;
                m_cnt = m_cnt + 16'd1;
                m_waitlow = 1;
            end
        end else if (m_waitlow) begin
            if (!ack) begin
                m_waitlow = 0;
                m_hold = 2;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (cnd != 0) begin
            for (int k = 3; k >= 0; k--)
                if (cnd[k]) m_id = 2'(k);
            m_int = 1;
        end
        m_pend = np | r;
        m_sq = src;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_int"}, 32'(int_req), 32'(m_int));
        chk({tag, "_pend"}, 32'(pending), 32'(m_pend));
        chk({tag, "_cnt"}, 32'(serviced_cnt), 32'(m_cnt));
        if (m_int) begin
            chk({tag, "_id"}, 32'(irq_id), 32'(m_id));
            chk({tag, "_vec"}, 32'(irq_vector), 32'(16'h0002 + 16'(m_id)));
        end
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        model_clk();
        #1;
        check_all(tag);
    endtask

    task automatic wait_int(string tag);
        int n;
        n = 0;
        while (!int_req && n < 20) begin
            cyc(tag);
            n++;
        end
        chk({tag, "_timeout"}, 32'(int_req), 32'd1);
    endtask

    initial begin
        reset = 1'b0; src = 4'h0; mask = 4'h0; ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_int", 32'(int_req), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_cnt", 32'(serviced_cnt), 32'd0);
        chk("rst_vec", 32'(irq_vector), 32'h0002);
        chk("rst_id", 32'(irq_id), 32'd0);
        reset = 1'b1;
        cyc("idle");

        // single source, single-cycle ack
        mask = 4'hF;
        src = 4'b0100;
        cyc("t2a");
        chk("t2_not_yet", 32'(int_req), 32'd0);
        cyc("t2b");
        chk("t2_int", 32'(int_req), 32'd1);
        chk("t2_id", 32'(irq_id), 32'd2);
        chk("t2_vec", 32'(irq_vector), 32'h0004);
        ack = 1'b1;
        cyc("t2c");
        ack = 1'b0;
        chk("t2_drop", 32'(int_req), 32'd0);
        chk("t2_pend", 32'(pending), 32'd0);
        chk("t2_cnt", 32'(serviced_cnt), 32'd1);
        src = 4'h0;
        repeat (5) cyc("t2d");

        // two simultaneous sources: priority, then gap
        src = 4'b1010;
        wait_int("t3a");
        chk("t3_id1", 32'(irq_id), 32'd1);
        ack = 1'b1;
        cyc("t3b");
        ack = 1'b0;
        cyc("t3c");
        cyc("t3d");
        chk("t3_gap_hold", 32'(int_req), 32'd0);
        wait_int("t3e");
        chk("t3_id3", 32'(irq_id), 32'd3);
        ack = 1'b1;
        cyc("t3f");
        ack = 1'b0;
        chk("t3_cnt", 32'(serviced_cnt), 32'd3);
        src = 4'h0;
        repeat (6) cyc("t3g");

        // masked source latches but does not request
        mask = 4'b1110;
        src = 4'b0001;
        repeat (4) cyc("t4a");
        chk("t4_pend", 32'(pending), 32'b0001);
        chk("t4_noint", 32'(int_req), 32'd0);
        mask = 4'hF;
        cyc("t4b");
        chk("t4_int", 32'(int_req), 32'd1);
        chk("t4_id", 32'(irq_id), 32'd0);
        ack = 1'b1;
        cyc("t4c");
        ack = 1'b0;
        src = 4'h0;
        repeat (6) cyc("t4d");

        // asynchronous reset mid-request
        src = 4'b1000;
        wait_int("t5a");
        #2;
        reset = 1'b0;
        #1;
        chk("t5_int", 32'(int_req), 32'd0);
        chk("t5_pend", 32'(pending), 32'd0);
        model_reset();
        src = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("t5b");

        // counter wrap and long ack
        force dut.serviced_cnt = 16'hFFFF;
        release dut.serviced_cnt;
        m_cnt = 16'hFFFF;
        src = 4'b0010;
        wait_int("t6a");
        ack = 1'b1;
        repeat (5) cyc("t6b");
        ack = 1'b0;
        chk("t6_wrap", 32'(serviced_cnt), 32'd0);
        src = 4'h0;
        repeat (6) cyc("t6c");
        chk("t6_once", 32'(serviced_cnt), 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            src  = 4'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            ack  = ($urandom_range(0, 2) == 0);
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
